// File: rtl/core_pkg.sv
// Shared RISC-X core types. The iterative multiply/divide unit uses these
// for its operation select and its FSM state.
package core_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide sharing one 2*DWIDTH accumulator and one DWIDTH+1 bit adder/subtractor.
module mdu
  import core_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  input  mdu_operation_t    operation_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o
);

  localparam int CW = $clog2(DWIDTH);

  mdu_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*DWIDTH-1:0]   acc_q, acc_d;
  logic [DWIDTH-1:0]     divisor_q, divisor_d;
  mdu_operation_t        op_q, op_d;
  logic                  negq_q, negq_d;
  logic                  negr_q, negr_d;
  logic [DWIDTH-1:0]     res_q, res_d;

  mdu_operation_t        op_sel;
  logic                  sgn1, sgn2, is_div_sel, div_zero, div_ovf;
  logic [DWIDTH-1:0]     mag1, mag2, special_res;

  logic                  is_div_q;
  logic [DWIDTH:0]       add_a, add_b, sum;
  logic [2*DWIDTH-1:0]   acc_step, prod;
  logic [DWIDTH-1:0]     quo, rem, final_res;

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign res_o   = res_q;

  // Decode the incoming request; unknown encodings fall back to MUL.
  always_comb begin
    op_sel = MDU_MUL;
    case (operation_i)
      MDU_MULH:   op_sel = MDU_MULH;
      MDU_MULHSU: op_sel = MDU_MULHSU;
      MDU_MULHU:  op_sel = MDU_MULHU;
      MDU_DIV:    op_sel = MDU_DIV;
      MDU_DIVU:   op_sel = MDU_DIVU;
      MDU_REM:    op_sel = MDU_REM;
      MDU_REMU:   op_sel = MDU_REMU;
      default:    op_sel = MDU_MUL;
    endcase

    is_div_sel = op_sel inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    sgn1 = (op_sel inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) && op1_i[DWIDTH-1];
    sgn2 = (op_sel inside {MDU_MULH, MDU_DIV, MDU_REM}) && op2_i[DWIDTH-1];
    mag1 = sgn1 ? -op1_i : op1_i;
    mag2 = sgn2 ? -op2_i : op2_i;

    div_zero = is_div_sel && (op2_i == '0);
    div_ovf  = (op_sel inside {MDU_DIV, MDU_REM}) &&
               (op1_i == {1'b1, {(DWIDTH-1){1'b0}}}) && (op2_i == '1);

    special_res = '0;
    if (div_zero)
      special_res = (op_sel inside {MDU_DIV, MDU_DIVU}) ? '1 : op1_i;
    else if (div_ovf)
      special_res = (op_sel == MDU_DIV) ? op1_i : '0;
  end

  // One iteration step. For divide the adder sees the shifted partial remainder
  // (one bit wider than DWIDTH) so large divisors never lose the top bit.
  always_comb begin
    is_div_q = op_q inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
    add_a    = is_div_q ? acc_q[2*DWIDTH-1:DWIDTH-1] : {1'b0, acc_q[2*DWIDTH-1:DWIDTH]};
    add_b    = {1'b0, divisor_q} ^ {(DWIDTH+1){is_div_q}};
    sum      = add_a + add_b + {{DWIDTH{1'b0}}, is_div_q};

    if (is_div_q)
      acc_step = sum[DWIDTH] ? {acc_q[2*DWIDTH-2:0], 1'b0}
                             : {sum[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
    else
      acc_step = acc_q[0] ? {sum, acc_q[DWIDTH-1:1]}
                          : {1'b0, acc_q[2*DWIDTH-1:1]};

    prod = negq_q ? -acc_step : acc_step;
    quo  = negq_q ? -acc_step[DWIDTH-1:0] : acc_step[DWIDTH-1:0];
    rem  = negr_q ? -acc_step[2*DWIDTH-1:DWIDTH] : acc_step[2*DWIDTH-1:DWIDTH];

    case (op_q)
      MDU_MUL:                       final_res = prod[DWIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[2*DWIDTH-1:DWIDTH];
      MDU_DIV, MDU_DIVU:             final_res = quo;
      default:                       final_res = rem;
    endcase
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    res_d     = res_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d      = op_sel;
          acc_d     = {{DWIDTH{1'b0}}, mag1};
          divisor_d = mag2;
          negq_d    = sgn1 ^ sgn2;
          negr_d    = sgn1;
          cnt_d     = '0;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DWIDTH-1)) begin
          res_d   = final_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      op_q      <= MDU_MUL;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the mdu: arithmetic results, result latency,
// special cases, backpressure, and kill by flush or reset.
module tb_mdu;
  import core_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           flush_i;
  logic           valid_i;
  logic           ready_o;
  logic [31:0]    op1_i;
  logic [31:0]    op2_i;
  mdu_operation_t operation_i;
  logic           valid_o;
  logic           ready_i;
  logic [31:0]    res_o;

  int checks   = 0;
  int failures = 0;

  mdu #(.DWIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .operation_i (operation_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .res_o       (res_o)
  );

  always #5 clk_i = ~clk_i;

  // Issue one op from IDLE, return its result and the number of edges after
  // the accept edge before valid_o was seen (0 = cycle N+1), then consume it.
  task automatic run_op(input mdu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk_i);
    valid_i = 1'b1; operation_i = op; op1_i = a; op2_i = b;
    @(negedge clk_i);
    valid_i = 1'b0; op1_i = 32'hDEADBEEF; op2_i = 32'h12345678;
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    res = res_o;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || res_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset: ready_o=%b valid_o=%b res_o=%h, required 1 0 00000000",
               ready_o, valid_o, res_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    run_op(MDU_MUL, 32'd7, 32'hFFFFFFFD, r, lat);
    checks++;
    if (r !== 32'hFFFFFFEB) begin
      failures++; $display("[TB] FAIL mul_7x-3: got %h, required ffffffeb", r);
    end
    checks++;
    if (lat !== 32) begin
      failures++; $display("[TB] FAIL mul_latency: got %0d edges, required 32", lat);
    end
    run_op(MDU_MULH, 32'h80000000, 32'h80000000, r, lat);
    checks++;
    if (r !== 32'h40000000) begin
      failures++; $display("[TB] FAIL mulh: got %h, required 40000000", r);
    end
    run_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
    checks++;
    if (r !== 32'hFFFFFFFE) begin
      failures++; $display("[TB] FAIL mulhu: got %h, required fffffffe", r);
    end
    run_op(MDU_MULHSU, 32'hFFFFFFFF, 32'd2, r, lat);
    checks++;
    if (r !== 32'hFFFFFFFF) begin
      failures++; $display("[TB] FAIL mulhsu: got %h, required ffffffff", r);
    end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, r, lat);
    checks++;
    if (r !== 32'hFFFFFFFD) begin
      failures++; $display("[TB] FAIL div_-7/2: got %h, required fffffffd", r);
    end
    checks++;
    if (lat !== 32) begin
      failures++; $display("[TB] FAIL div_latency: got %0d edges, required 32", lat);
    end
    run_op(MDU_REM, 32'hFFFFFFF9, 32'd2, r, lat);
    checks++;
    if (r !== 32'hFFFFFFFF) begin
      failures++; $display("[TB] FAIL rem_-7%%2: got %h, required ffffffff", r);
    end
    run_op(MDU_DIVU, 32'd7, 32'd2, r, lat);
    checks++;
    if (r !== 32'd3) begin
      failures++; $display("[TB] FAIL divu_7/2: got %h, required 00000003", r);
    end
    run_op(MDU_DIV, 32'd100, 32'hFFFFFFF9, r, lat);
    checks++;
    if (r !== 32'hFFFFFFF2) begin
      failures++; $display("[TB] FAIL div_100/-7: got %h, required fffffff2", r);
    end
    run_op(MDU_REMU, 32'hFFFFFFFF, 32'h80000001, r, lat);
    checks++;
    if (r !== 32'h7FFFFFFE) begin
      failures++; $display("[TB] FAIL remu_big_divisor: got %h, required 7ffffffe", r);
    end
  endtask

  task automatic test_special();
    logic [31:0] r;
    int lat;
    run_op(MDU_DIVU, 32'd5, 32'd0, r, lat);
    checks++;
    if (r !== 32'hFFFFFFFF || lat !== 0) begin
      failures++; $display("[TB] FAIL divu_by_zero: got %h lat %0d, required ffffffff lat 0", r, lat);
    end
    run_op(MDU_REMU, 32'd5, 32'd0, r, lat);
    checks++;
    if (r !== 32'd5 || lat !== 0) begin
      failures++; $display("[TB] FAIL remu_by_zero: got %h lat %0d, required 00000005 lat 0", r, lat);
    end
    run_op(MDU_REM, 32'hFFFFFFFB, 32'd0, r, lat);
    checks++;
    if (r !== 32'hFFFFFFFB || lat !== 0) begin
      failures++; $display("[TB] FAIL rem_by_zero: got %h lat %0d, required fffffffb lat 0", r, lat);
    end
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat);
    checks++;
    if (r !== 32'h80000000 || lat !== 0) begin
      failures++; $display("[TB] FAIL div_overflow: got %h lat %0d, required 80000000 lat 0", r, lat);
    end
    run_op(MDU_REM, 32'h80000000, 32'hFFFFFFFF, r, lat);
    checks++;
    if (r !== 32'h0 || lat !== 0) begin
      failures++; $display("[TB] FAIL rem_overflow: got %h lat %0d, required 00000000 lat 0", r, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk_i);
    valid_i = 1'b1; operation_i = MDU_DIVU; op1_i = 32'd100; op2_i = 32'd7;
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || res_o !== 32'd14) begin
        failures++;
        $display("[TB] FAIL backpressure_hold[%0d]: valid_o=%b ready_o=%b res_o=%h, required 1 0 0000000e",
                 i, valid_o, ready_o, res_o);
      end
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL backpressure_release: ready_o=%b valid_o=%b, required 1 0", ready_o, valid_o);
    end
  endtask

  // Kill a DIV in cycle N+10 with flush (use_rst=0) or reset (use_rst=1).
  task automatic test_kill(input bit use_rst);
    logic [31:0] r;
    int lat;
    int seen;
    @(negedge clk_i);
    valid_i = 1'b1; operation_i = MDU_DIV; op1_i = 32'd1000; op2_i = 32'd3;
    @(negedge clk_i);
    valid_i = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL kill_calc_busy(rst=%0d): ready_o=%b valid_o=%b, required 0 0", use_rst, ready_o, valid_o);
    end
    if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || res_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL kill_idle(rst=%0d): ready_o=%b valid_o=%b res_o=%h, required 1 0 00000000",
               use_rst, ready_o, valid_o, res_o);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seen++;
      @(negedge clk_i);
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("[TB] FAIL kill_no_result(rst=%0d): valid_o seen %0d cycles, required 0", use_rst, seen);
    end
    run_op(MDU_MUL, 32'd3, 32'd4, r, lat);
    checks++;
    if (r !== 32'd12 || lat !== 32) begin
      failures++;
      $display("[TB] FAIL kill_then_mul(rst=%0d): got %h lat %0d, required 0000000c lat 32", use_rst, r, lat);
    end
  endtask

  task automatic test_flush_request();
    int seen;
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; operation_i = MDU_DIVU; op1_i = 32'd9; op2_i = 32'd0;
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o || !ready_o) seen++;
      @(negedge clk_i);
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("[TB] FAIL flush_with_request: unit busy/valid %0d cycles, required 0", seen);
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op1_i = '0; op2_i = '0; operation_i = MDU_MUL;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_kill(1'b0);
    test_kill(1'b1);
    test_flush_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
